// File: rtl/state_var_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : state_var_eval_sequencer
// Description : Fetches the initial state variables from memory. Then runs
//               NUM_EVAL_VAL evaluation passes. Each pass chains NUM_PHASES
//               sub-engines and shares NUM_ADDERS FP adders among them. Each
//               pass writes its last-phase result back to state-var memory.
// Option      : define SVE_PHASE_TIMEOUT_EN to enable a per-phase watchdog
//               that moves the sequencer to an ERROR state.
// Revision    : 1.0 - initial release
// ============================================================================
module state_var_eval_sequencer #(
   parameter  int NUM_INIT_VAL   = 6,
   parameter  int NUM_EVAL_VAL   = 3,
   parameter  int NUM_PHASES     = 3,
   parameter  int NUM_ADDERS     = 2,
   parameter  int DATA_WIDTH     = 32,
   parameter  int TIMEOUT_CYCLES = 4096,
   localparam int AW             = $clog2(NUM_INIT_VAL + NUM_EVAL_VAL)
) (
   input  logic                                       clock,
   input  logic                                       reset,
   input  logic                                       start,
   input  logic                                       abort,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       error,
   output logic [AW-1:0]                              mem_sv_rd_addr,
   input  logic [DATA_WIDTH-1:0]                      mem_sv_rd_data,
   output logic [AW-1:0]                              mem_sv_wr_addr,
   output logic [DATA_WIDTH-1:0]                      mem_sv_wr_data,
   output logic                                       mem_sv_we,
   output logic [NUM_INIT_VAL*DATA_WIDTH-1:0]         init_val_out,
   output logic [NUM_PHASES-1:0]                      phase_start,
   input  logic [NUM_PHASES-1:0]                      phase_done,
   input  logic [DATA_WIDTH-1:0]                      result_data,
   input  logic [NUM_PHASES*NUM_ADDERS*DATA_WIDTH-1:0] phase_add_a,
   input  logic [NUM_PHASES*NUM_ADDERS*DATA_WIDTH-1:0] phase_add_b,
   input  logic [NUM_PHASES*NUM_ADDERS-1:0]           phase_add_start,
   output logic [NUM_ADDERS*DATA_WIDTH-1:0]           add_a,
   output logic [NUM_ADDERS*DATA_WIDTH-1:0]           add_b,
   output logic [NUM_ADDERS-1:0]                      add_start
);

   localparam int c_FW    = $clog2(NUM_INIT_VAL + 1);
   localparam int c_PW    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
   localparam int c_NW    = $clog2(NUM_EVAL_VAL + 1);
   localparam int c_SLICE = NUM_ADDERS * DATA_WIDTH;

   typedef logic [c_FW-1:0] fcnt_t;
   typedef logic [c_PW-1:0] phase_t;
   typedef logic [c_NW-1:0] pass_t;
   typedef logic [AW-1:0]   addr_t;

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_FETCH    = 3'd1;
   localparam logic [2:0] c_PH_START = 3'd2;
   localparam logic [2:0] c_PH_WAIT  = 3'd3;
   localparam logic [2:0] c_WRITE    = 3'd4;
   localparam logic [2:0] c_DONE     = 3'd5;
`ifdef SVE_PHASE_TIMEOUT_EN
   localparam logic [2:0] c_ERROR    = 3'd6;
   localparam int         c_TW       = $clog2(TIMEOUT_CYCLES + 1);
   typedef logic [c_TW-1:0] tmo_t;
`endif

   // The watchdog limit must leave room for at least one waiting cycle
   generate
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   logic [2:0]                          r_state;
   logic [2:0]                          w_state_next;
   fcnt_t                               r_fetch_cnt;
   phase_t                              r_phase;
   pass_t                               r_pass;
   logic [DATA_WIDTH-1:0]               r_result;
   logic [NUM_INIT_VAL*DATA_WIDTH-1:0]  r_init_val;
   logic                                w_busy;
   logic                                w_abort;
   logic                                w_phase_done;
   logic                                w_last_phase;
   logic                                w_last_pass;
   logic                                w_timeout;

   assign w_busy       = (r_state == c_FETCH) || (r_state == c_PH_START) ||
                         (r_state == c_PH_WAIT) || (r_state == c_WRITE);
   assign w_abort      = abort && w_busy;
   assign w_last_phase = (r_phase == phase_t'(NUM_PHASES - 1));
   assign w_last_pass  = (r_pass == pass_t'(NUM_EVAL_VAL - 1));

   // Only the done bit of the phase currently running is observed
   always_comb begin
      w_phase_done = 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (r_phase == phase_t'(i)) begin
            w_phase_done = phase_done[i];
         end
      end
   end

`ifdef SVE_PHASE_TIMEOUT_EN
   tmo_t r_tmo_cnt;

   // Watchdog counts waiting cycles; it restarts whenever a phase is launched
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tmo_cnt <= '0;
      end else if (r_state == c_PH_WAIT) begin
         r_tmo_cnt <= r_tmo_cnt + tmo_t'(1);
      end else begin
         r_tmo_cnt <= '0;
      end
   end

   assign w_timeout = (r_state == c_PH_WAIT) &&
                      (r_tmo_cnt == tmo_t'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; abort overrides every busy-state transition
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE:     if (start) w_state_next = c_FETCH;
         c_FETCH:    if (r_fetch_cnt == fcnt_t'(NUM_INIT_VAL)) w_state_next = c_PH_START;
         c_PH_START: w_state_next = c_PH_WAIT;
         c_PH_WAIT: begin
            if (w_phase_done) begin
               w_state_next = w_last_phase ? c_WRITE : c_PH_START;
            end
`ifdef SVE_PHASE_TIMEOUT_EN
            else if (w_timeout) begin
               w_state_next = c_ERROR;
            end
`endif
         end
         c_WRITE:    w_state_next = w_last_pass ? c_DONE : c_PH_START;
         c_DONE:     w_state_next = c_IDLE;
`ifdef SVE_PHASE_TIMEOUT_EN
         c_ERROR:    if (start) w_state_next = c_FETCH;
`endif
         default:    w_state_next = c_IDLE;
      endcase
      if (w_abort) begin
         w_state_next = c_IDLE;
      end
   end

   // Outputs decoded from state; phase_start and we are gated by abort
   always_comb begin
      busy           = w_busy;
      done           = (r_state == c_DONE);
`ifdef SVE_PHASE_TIMEOUT_EN
      error          = (r_state == c_ERROR);
`else
      error          = 1'b0;
`endif
      mem_sv_rd_addr = '0;
      mem_sv_wr_addr = '0;
      mem_sv_wr_data = '0;
      mem_sv_we      = 1'b0;
      phase_start    = '0;
      add_a          = '0;
      add_b          = '0;
      add_start      = '0;
      init_val_out   = r_init_val;
      if ((r_state == c_FETCH) && (r_fetch_cnt < fcnt_t'(NUM_INIT_VAL))) begin
         mem_sv_rd_addr = addr_t'(r_fetch_cnt);
      end
      if ((r_state == c_WRITE) && !abort) begin
         mem_sv_we      = 1'b1;
         mem_sv_wr_addr = addr_t'(NUM_INIT_VAL) + addr_t'(r_pass);
         mem_sv_wr_data = r_result;
      end
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (r_phase == phase_t'(i)) begin
            if ((r_state == c_PH_START) && !abort) begin
               phase_start[i] = 1'b1;
            end
            if (r_state == c_PH_WAIT) begin
               add_a     = phase_add_a[i*c_SLICE +: c_SLICE];
               add_b     = phase_add_b[i*c_SLICE +: c_SLICE];
               add_start = phase_add_start[i*NUM_ADDERS +: NUM_ADDERS];
            end
         end
      end
   end

   // Fetch counter, phase/pass indices, initial-value and result capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fetch_cnt <= '0;
         r_phase     <= '0;
         r_pass      <= '0;
         r_result    <= '0;
         r_init_val  <= '0;
      end else begin
         r_fetch_cnt <= '0;
         if (w_abort) begin
            r_phase <= '0;
            r_pass  <= '0;
         end else begin
            case (r_state)
               c_IDLE: begin
                  r_phase <= '0;
                  r_pass  <= '0;
               end
`ifdef SVE_PHASE_TIMEOUT_EN
               c_ERROR: begin
                  r_phase <= '0;
                  r_pass  <= '0;
               end
`endif
               c_FETCH: begin
                  r_fetch_cnt <= r_fetch_cnt + fcnt_t'(1);
                  // Read data lags the address by one cycle
                  for (int i = 0; i < NUM_INIT_VAL; i++) begin
                     if (r_fetch_cnt == fcnt_t'(i + 1)) begin
                        r_init_val[i*DATA_WIDTH +: DATA_WIDTH] <= mem_sv_rd_data;
                     end
                  end
               end
               c_PH_WAIT: begin
                  if (w_phase_done) begin
                     if (w_last_phase) begin
                        r_result <= result_data;
                     end else begin
                        r_phase <= r_phase + phase_t'(1);
                     end
                  end
               end
               c_WRITE: begin
                  r_phase <= '0;
                  r_pass  <= r_pass + pass_t'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
